// File: rtl/mux4_rr_sched.sv
// mux4_rr_sched: round-robin scheduler for a shared 4:1 operand mux with a
// registered valid/ready output stage.
// Optional feature: define MUX4_SCHED_LOCK_EN to add the lock[3:0] port.
// With it, a locked previous winner keeps the grant for multi-beat bursts.
module mux4_rr_sched #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  output logic [3:0]       ack,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
`ifdef MUX4_SCHED_LOCK_EN
  ,
  input  logic [3:0]       lock
`endif
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state;
  logic [1:0]       ptr;
  logic             load;
  logic             rr_found;
  logic [1:0]       rr_win;
  logic [1:0]       scan_idx;
  logic [1:0]       win;
  logic [1:0]       next_ptr;
  logic [WIDTH-1:0] win_data;

`ifdef MUX4_SCHED_LOCK_EN
  logic             have_prev;
  logic             keep;
`endif

  // A new beat is taken whenever someone requests and the output slot is free
  // or being drained on this same edge.
  always_comb begin
    load = (|req) && ((state == EMPTY) || out_ready);
  end

  // Round-robin scan starting at ptr, wrapping mod 4.
  always_comb begin
    rr_found = 1'b0;
    rr_win   = ptr;
    scan_idx = ptr;
    for (int k = 0; k < 4; k++) begin
      scan_idx = ptr + 2'(k);
      if (!rr_found && req[scan_idx]) begin
        rr_found = 1'b1;
        rr_win   = scan_idx;
      end
    end
  end

`ifdef MUX4_SCHED_LOCK_EN
  // A locked previous winner that still requests keeps the grant; the pointer
  // then stays put so rotation resumes where it left off once the burst ends.
  always_comb begin
    keep     = have_prev && lock[sel] && req[sel];
    win      = keep ? sel : rr_win;
    next_ptr = keep ? ptr : (win + 2'd1);
  end
`else
  // Pure round-robin: the winner becomes lowest priority next round.
  always_comb begin
    win      = rr_win;
    next_ptr = rr_win + 2'd1;
  end
`endif

  // One-hot accept, only on a load edge; no path from the operands.
  always_comb begin
    ack = load ? (4'b0001 << win) : 4'b0000;
  end

  // Shared 4:1 operand mux.
  always_comb begin
    win_data = in0;
    case (win)
      2'd0: win_data = in0;
      2'd1: win_data = in1;
      2'd2: win_data = in2;
      2'd3: win_data = in3;
      default: win_data = in0;
    endcase
  end

  // EMPTY/FULL output-stage FSM with registered select, data and valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      out_data  <= '0;
      sel       <= 2'b00;
      ptr       <= 2'b00;
`ifdef MUX4_SCHED_LOCK_EN
      have_prev <= 1'b0;
`endif
    end else begin
      case (state)
        EMPTY: begin
          if (load) begin
            state     <= FULL;
            out_valid <= 1'b1;
            out_data  <= win_data;
            sel       <= win;
            ptr       <= next_ptr;
`ifdef MUX4_SCHED_LOCK_EN
            have_prev <= 1'b1;
`endif
          end
        end
        FULL: begin
          if (load) begin
            out_valid <= 1'b1;
            out_data  <= win_data;
            sel       <= win;
            ptr       <= next_ptr;
`ifdef MUX4_SCHED_LOCK_EN
            have_prev <= 1'b1;
`endif
          end else if (out_ready) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
